// File: rtl/sd_port_arbiter.sv
// N-port request/grant arbiter for the shared SD card interface.
// Round-robin or fixed-priority winner, optional hold timeout, ownership frozen while SD_Busy.
module sd_port_arbiter #(
  parameter int N        = 6,
  parameter int IDX_W    = 3,
  parameter int MODE     = 0,
  parameter int MAX_HOLD = 0
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [N-1:0]     Request,
  input  logic             SD_Busy,
  input  logic             Clear,
  output logic [N-1:0]     Grant,
  output logic [IDX_W-1:0] Grant_Index,
  output logic             Grant_Valid,
  output logic [N-1:0]     Timeout_Flags
);

  localparam int PW    = (N > 1) ? $clog2(N) : 1;
  localparam int CNT_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
  localparam logic [CNT_W-1:0] HOLD_SAT = CNT_W'(MAX_HOLD);
  localparam logic [N-1:0]     ONE_HOT0 = N'(1);
  localparam logic [PW-1:0]    LAST     = PW'(N - 1);

  typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

  state_t           state;
  logic [PW-1:0]    ptr;
  logic [PW-1:0]    owner;
  logic [PW-1:0]    winner;
  logic [CNT_W-1:0] hold_cnt;
  logic [N-1:0]     elig;
  logic [N-1:0]     cand;
  logic [N-1:0]     expire_vec;
  logic [N-1:0]     flags_nxt;
  logic [N-1:0]     elig_nxt;
  logic             owner_req;
  logic             expired;
  logic             timeout;
  logic             can_grant;

  // Circular search from start in round-robin mode, plain lowest-index search otherwise.
  function automatic logic [PW-1:0] pick(input logic [N-1:0] req, input logic [PW-1:0] start);
    logic [PW:0]   s;
    logic [PW-1:0] win;
    logic          found;
    win   = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      s = (MODE == 0) ? ({1'b0, start} + (PW+1)'(i)) : (PW+1)'(i);
      if (s >= (PW+1)'(N)) s = s - (PW+1)'(N);
      if (!found && req[s[PW-1:0]]) begin
        win   = s[PW-1:0];
        found = 1'b1;
      end
    end
    return win;
  endfunction

  always_comb begin
    cand       = Request & elig;
    winner     = pick(cand, ptr);
    owner_req  = |(Request & Grant);
    expired    = (MAX_HOLD > 0) && (hold_cnt >= HOLD_LIM);
    timeout    = (state == GRANT) && owner_req && expired && !SD_Busy;
    expire_vec = timeout ? Grant : '0;
    // A timeout landing with Clear still records its own bit.
    flags_nxt  = (Clear ? '0 : Timeout_Flags) | expire_vec;
    elig_nxt   = (elig | ~Request) & ~expire_vec;
    // RELEASE already carries the dead cycle, so it may pick the next owner.
    can_grant  = (state != GRANT) && (|cand) && !SD_Busy;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state         <= IDLE;
      Grant         <= '0;
      Grant_Index   <= '0;
      Grant_Valid   <= 1'b0;
      Timeout_Flags <= '0;
      ptr           <= '0;
      owner         <= '0;
      hold_cnt      <= '0;
      elig          <= '1;
    end else begin
      Timeout_Flags <= flags_nxt;
      elig          <= elig_nxt;
      case (state)
        GRANT: begin
          if (!owner_req || timeout) begin
            state       <= RELEASE;
            Grant       <= '0;
            Grant_Index <= '0;
            Grant_Valid <= 1'b0;
            if (MODE == 0) ptr <= (owner == LAST) ? '0 : owner + PW'(1);
          end
          if (hold_cnt != HOLD_SAT) hold_cnt <= hold_cnt + CNT_W'(1);
        end
        default: begin
          if (can_grant) begin
            state       <= GRANT;
            Grant       <= ONE_HOT0 << winner;
            Grant_Index <= IDX_W'(winner);
            Grant_Valid <= 1'b1;
            owner       <= winner;
            hold_cnt    <= '0;
          end else begin
            state       <= IDLE;
            Grant       <= '0;
            Grant_Index <= '0;
            Grant_Valid <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sd_port_arbiter.sv
// Bench for sd_port_arbiter: a round-robin and a fixed-priority instance (N=6, MAX_HOLD=16)
// tracked every cycle against an owner/hold-count reference model, plus directed scenarios.
module tb_sd_port_arbiter;

  localparam int NP   = 6;
  localparam int MAXH = 16;

  logic       Clk = 1'b0;
  logic       Reset;
  logic [5:0] req0, req1;
  logic       busy0, busy1, clr0, clr1;
  logic [5:0] gnt0, gnt1, flg0, flg1;
  logic [2:0] idx0, idx1;
  logic       vld0, vld1;

  always #5 Clk = ~Clk;

  sd_port_arbiter #(.N(NP), .IDX_W(3), .MODE(0), .MAX_HOLD(MAXH)) u_rr (
    .Clk(Clk), .Reset(Reset), .Request(req0), .SD_Busy(busy0), .Clear(clr0),
    .Grant(gnt0), .Grant_Index(idx0), .Grant_Valid(vld0), .Timeout_Flags(flg0));

  sd_port_arbiter #(.N(NP), .IDX_W(3), .MODE(1), .MAX_HOLD(MAXH)) u_fp (
    .Clk(Clk), .Reset(Reset), .Request(req1), .SD_Busy(busy1), .Clear(clr1),
    .Grant(gnt1), .Grant_Index(idx1), .Grant_Valid(vld1), .Timeout_Flags(flg1));

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  // Reference model: owner is -1 when nobody holds the interface; hold counts completed grant cycles.
  int       m_own[2];
  int       m_hold[2];
  int       m_ptr[2];
  bit [5:0] m_blk[2];
  bit [5:0] m_flg[2];

  task automatic model_step(input int m, input bit rst, input bit [5:0] req,
                            input bit busy, input bit clr, input int mode);
    int w;
    int p;
    if (rst) begin
      m_own[m] = -1; m_hold[m] = 0; m_ptr[m] = 0; m_blk[m] = '0; m_flg[m] = '0;
      return;
    end
    if (clr) m_flg[m] = '0;
    m_blk[m] = m_blk[m] & req;
    if (m_own[m] >= 0) begin
      m_hold[m] = m_hold[m] + 1;
      if (!req[m_own[m]]) begin
        if (mode == 0) m_ptr[m] = (m_own[m] + 1) % NP;
        m_own[m] = -1;
      end else if (m_hold[m] >= MAXH && !busy) begin
        m_flg[m][m_own[m]] = 1'b1;
        m_blk[m][m_own[m]] = 1'b1;
        if (mode == 0) m_ptr[m] = (m_own[m] + 1) % NP;
        m_own[m] = -1;
      end
    end else if (!busy) begin
      w = -1;
      for (int i = 0; i < NP; i++) begin
        p = (mode == 0) ? (m_ptr[m] + i) % NP : i;
        if (w < 0 && req[p] && !m_blk[m][p]) w = p;
      end
      if (w >= 0) begin
        m_own[m]  = w;
        m_hold[m] = 0;
      end
    end
  endtask

  function automatic logic [31:0] exp_g(input int m);
    return (m_own[m] >= 0) ? (32'd1 << m_own[m]) : 32'd0;
  endfunction

  function automatic logic [31:0] exp_i(input int m);
    return (m_own[m] >= 0) ? 32'(m_own[m]) : 32'd0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    model_step(0, Reset, req0, busy0, clr0, 0);
    model_step(1, Reset, req1, busy1, clr1, 1);
    @(posedge Clk);
    #1;
    chk("rr_grant", 32'(gnt0), exp_g(0));
    chk("rr_index", 32'(idx0), exp_i(0));
    chk("rr_valid", 32'(vld0), 32'(m_own[0] >= 0));
    chk("rr_flags", 32'(flg0), 32'(m_flg[0]));
    chk("fp_grant", 32'(gnt1), exp_g(1));
    chk("fp_index", 32'(idx1), exp_i(1));
    chk("fp_valid", 32'(vld1), 32'(m_own[1] >= 0));
    chk("fp_flags", 32'(flg1), 32'(m_flg[1]));
  endtask

  int order[7];
  int gaps[7];
  int exp_order[7] = '{0, 1, 2, 3, 4, 5, 0};
  int seen, run, gap, dropped, n;
  bit pend;

  initial begin
    Reset = 1'b1;
    req0 = '0; req1 = '0; busy0 = 1'b0; busy1 = 1'b0; clr0 = 1'b0; clr1 = 1'b0;
    tick(); tick();
    chk("reset_grant", 32'(gnt0), 32'd0);
    chk("reset_valid", 32'(vld0), 32'd0);
    chk("reset_flags", 32'(flg0), 32'd0);
    Reset = 1'b0;
    tick();

    // Round-robin fairness: each owner keeps the grant for 4 cycles, re-requests 1 cycle later.
    req0 = 6'b111111; seen = 0; run = 0; gap = 0; pend = 1'b0; dropped = 0;
    for (int c = 0; c < 120 && seen < 7; c++) begin
      tick();
      if (vld0) begin
        if (run == 0) begin
          order[seen] = int'(idx0);
          gaps[seen]  = gap;
          chk("rr_onehot_vs_index", 32'(gnt0), 32'd1 << idx0);
          seen++;
        end
        run++;
        gap = 0;
        if (run == 4) begin
          dropped = int'(idx0);
          req0 = req0 & ~(6'b000001 << idx0);
          pend = 1'b1;
        end
      end else begin
        gap++;
        run = 0;
        if (pend) begin
          req0 = req0 | (6'b000001 << dropped);
          pend = 1'b0;
        end
      end
    end
    chk("rr_grants_seen", 32'(seen), 32'd7);
    for (int k = 0; k < 7; k++) chk("rr_order", 32'(order[k]), 32'(exp_order[k]));
    for (int k = 1; k < 7; k++) chk("rr_gap", 32'(gaps[k]), 32'd1);
    req0 = '0;
    tick(); tick();

    // Timeout on port 1: 16 cycles of grant, flag set, blocked until Request seen low.
    req0 = 6'b000010; n = 0;
    for (int c = 0; c < 60; c++) begin
      tick();
      if (vld0) n++;
      else if (n > 0) break;
    end
    chk("to_len", 32'(n), 32'd16);
    chk("to_flags", 32'(flg0), 32'h02);
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("to_no_regrant", 32'(gnt0), 32'd0);
    end
    req0 = '0; tick();
    req0 = 6'b000010; tick();
    chk("to_regrant", 32'(gnt0), 32'h02);
    req0 = '0; tick(); tick();

    // Clear in the same cycle as port 4 times out, flag 1 already set.
    req0 = 6'b010000; n = 0;
    for (int c = 0; c < 60; c++) begin
      tick();
      if (vld0) n++;
      if (n == 16) break;
    end
    chk("clr_hold_len", 32'(n), 32'd16);
    clr0 = 1'b1; tick(); clr0 = 1'b0;
    chk("clr_collision_flags", 32'(flg0), 32'h10);
    chk("clr_collision_grant", 32'(gnt0), 32'd0);
    req0 = '0; tick(); tick();

    // Busy interlock: SD_Busy from hold cycle 10 through 25 stretches the grant.
    req0 = 6'b000100; n = 0;
    for (int c = 0; c < 80; c++) begin
      tick();
      if (vld0) n++;
      else if (n > 0) break;
      if (n == 10) busy0 = 1'b1;
      if (n == 25) busy0 = 1'b0;
    end
    busy0 = 1'b0;
    chk("busy_len", 32'(n), 32'd25);
    chk("busy_flags", 32'(flg0), 32'h14);
    req0 = '0; tick(); tick();

    // Busy while idle blocks a new grant; grant follows one edge after Busy falls.
    busy0 = 1'b1; req0 = 6'b001000;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("busy_idle_grant", 32'(gnt0), 32'd0);
    end
    busy0 = 1'b0; tick();
    chk("busy_idle_release", 32'(gnt0), 32'h08);
    tick(); tick();

    // Reset mid-grant on port 3 with flags set, then a fresh Request[5].
    Reset = 1'b1; tick(); Reset = 1'b0;
    chk("midreset_grant", 32'(gnt0), 32'd0);
    chk("midreset_flags", 32'(flg0), 32'd0);
    req0 = 6'b100000; tick();
    chk("midreset_regrant", 32'(gnt0), 32'h20);
    chk("midreset_index", 32'(idx0), 32'd5);
    req0 = '0; tick(); tick();

    // Fixed priority: 2 and 4 requesting, 0 arrives during port 2's grant.
    req1 = 6'b010100; tick();
    chk("fp_first", 32'(gnt1), 32'h04);
    tick();
    req1 = 6'b010101;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("fp_hold", 32'(gnt1), 32'h04);
    end
    req1 = 6'b010001; tick();
    chk("fp_dead", 32'(gnt1), 32'd0);
    tick();
    chk("fp_second", 32'(gnt1), 32'h01);
    tick();
    req1 = 6'b010000; tick(); tick();
    chk("fp_third", 32'(gnt1), 32'h10);
    req1 = '0; tick(); tick();

    // Randomized traffic on both instances against the model.
    for (int c = 0; c < 500; c++) begin
      req0  = req0 ^ (6'($urandom) & 6'($urandom) & 6'($urandom));
      req1  = req1 ^ (6'($urandom) & 6'($urandom) & 6'($urandom));
      busy0 = ($urandom_range(0, 4) == 0);
      busy1 = ($urandom_range(0, 4) == 0);
      clr0  = ($urandom_range(0, 19) == 0);
      clr1  = ($urandom_range(0, 19) == 0);
      Reset = ($urandom_range(0, 149) == 0);
      tick();
    end
    Reset = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
